// File: rtl/relu_bwd_stream_if.sv
// Handshake/bus bundle for relu_bwd_stream.
// master: the surrounding datapath (drives activations, gradients, out_ready, flush).
// slave : the relu_bwd_stream block itself.
interface relu_bwd_stream_if #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 act_valid;
    logic                 act_ready;
    logic [N*WIDTH-1:0]   act_in;
    logic                 grad_valid;
    logic                 grad_ready;
    logic [N*WIDTH-1:0]   grad_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*WIDTH-1:0]   grad_out;
    logic                 flush;
    logic [CW-1:0]        mask_count;

    modport master (
        output act_valid, act_in, grad_valid, grad_in, out_ready, flush,
        input  act_ready, grad_ready, out_valid, grad_out, mask_count
    );

    modport slave (
        input  act_valid, act_in, grad_valid, grad_in, out_ready, flush,
        output act_ready, grad_ready, out_valid, grad_out, mask_count
    );
endinterface

// File: rtl/relu_bwd_stream.sv
// Streaming ReLU backward path: a mask FIFO filled from pre-activations and
// drained one entry per gradient vector, with a registered valid/ready output.
// Optional build macro RELU_BWD_LEAKY_EN: masked-out lanes carry
// grad_in >>> LEAK_SHIFT instead of zero.
module relu_bwd_stream #(
    parameter int WIDTH      = 16,
    parameter int N          = 4,
    parameter int DEPTH      = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    relu_bwd_stream_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Parameter sanity: DEPTH must be a power of two >= 2 so pointers wrap freely.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (LEAK_SHIFT < 0) || (LEAK_SHIFT >= WIDTH)) begin : g_bad_params
        $error("relu_bwd_stream: illegal DEPTH or LEAK_SHIFT");
    end

    logic [N-1:0]       mask_mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               push;
    logic               pop;
    logic [N-1:0]       act_mask;
    logic [N-1:0]       rd_mask;
    logic [N*WIDTH-1:0] gated;
    logic               out_valid_q;
    logic [N*WIDTH-1:0] grad_out_q;

    assign bus.act_ready  = (count != CW'(DEPTH));
    assign bus.grad_ready = (count != '0) && (!out_valid_q || bus.out_ready);
    assign bus.out_valid  = out_valid_q;
    assign bus.grad_out   = grad_out_q;
    assign bus.mask_count = count;

    // A same-cycle flush cancels both the push and the pop.
    assign push = bus.act_valid  && bus.act_ready  && !bus.flush;
    assign pop  = bus.grad_valid && bus.grad_ready && !bus.flush;

    assign rd_mask = mask_mem[rd_ptr];

    // Per-lane positivity mask of the incoming activation and gating of the gradient.
    always_comb begin
        act_mask = '0;
        gated    = '0;
        for (int i = 0; i < N; i++) begin
            act_mask[i] = !bus.act_in[i*WIDTH + WIDTH - 1] && (|bus.act_in[i*WIDTH +: WIDTH]);
            if (rd_mask[i]) begin
                gated[i*WIDTH +: WIDTH] = bus.grad_in[i*WIDTH +: WIDTH];
            end else begin
`ifdef RELU_BWD_LEAKY_EN
                gated[i*WIDTH +: WIDTH] = $signed(bus.grad_in[i*WIDTH +: WIDTH]) >>> LEAK_SHIFT;
`else
                gated[i*WIDTH +: WIDTH] = '0;
`endif
            end
        end
    end

    // Mask storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wr_ptr] <= act_mask;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered output stage; holds while stalled, untouched by flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            grad_out_q  <= '0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            grad_out_q  <= gated;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_relu_bwd_stream.sv
// Self-checking bench for relu_bwd_stream against a queue-based reference model.
module tb_relu_bwd_stream;
    localparam int WIDTH      = 16;
    localparam int N          = 4;
    localparam int DEPTH      = 8;
    localparam int LEAK_SHIFT = 3;
    localparam int CW         = $clog2(DEPTH) + 1;
    localparam int VW         = N * WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    relu_bwd_stream_if #(.WIDTH(WIDTH), .N(N), .DEPTH(DEPTH)) bus ();

    relu_bwd_stream #(
        .WIDTH(WIDTH), .N(N), .DEPTH(DEPTH), .LEAK_SHIFT(LEAK_SHIFT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: queue of masks plus the expected output register.
    logic [N-1:0]  mq [$];
    logic          mv   = 1'b0;
    logic [VW-1:0] mout = '0;

    function automatic logic [N-1:0] ref_mask(input logic [VW-1:0] v);
        logic [N-1:0] m;
        int x;
        for (int i = 0; i < N; i++) begin
            x    = int'($signed(v[i*WIDTH +: WIDTH]));
            m[i] = (x > 0);
        end
        return m;
    endfunction

    function automatic logic [VW-1:0] ref_gate(input logic [N-1:0] m, input logic [VW-1:0] g);
        logic [VW-1:0] r;
        int x, y, d;
        d = 1 << LEAK_SHIFT;
        for (int i = 0; i < N; i++) begin
            x = int'($signed(g[i*WIDTH +: WIDTH]));
            if (m[i]) begin
                y = x;
            end else begin
`ifdef RELU_BWD_LEAKY_EN
                y = x / d;
                if ((x % d != 0) && (x < 0)) y = y - 1;
`else
                y = 0;
`endif
            end
            r[i*WIDTH +: WIDTH] = WIDTH'(y);
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] pack(input int a, input int b, input int c, input int d);
        logic [VW-1:0] v;
        v[0*WIDTH +: WIDTH] = WIDTH'(a);
        v[1*WIDTH +: WIDTH] = WIDTH'(b);
        v[2*WIDTH +: WIDTH] = WIDTH'(c);
        v[3*WIDTH +: WIDTH] = WIDTH'(d);
        return v;
    endfunction

    // Random vector biased toward sign/zero boundary values.
    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        int x;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 7))
                0:       x = 0;
                1:       x = -32768;
                2:       x = 32767;
                3:       x = 1;
                4:       x = -1;
                default: x = int'($urandom_range(0, 65535)) - 32768;
            endcase
            v[i*WIDTH +: WIDTH] = WIDTH'(x);
        end
        return v;
    endfunction

    // Vector whose positive lanes follow the bits of code.
    function automatic logic [VW-1:0] code_vec(input int code);
        logic [VW-1:0] v;
        int x;
        for (int i = 0; i < N; i++) begin
            if (((code >> i) & 1) != 0) x = int'($urandom_range(1, 32767));
            else                        x = -int'($urandom_range(0, 32768));
            v[i*WIDTH +: WIDTH] = WIDTH'(x);
        end
        return v;
    endfunction

    // Apply inputs on the falling edge, then settle.
    task automatic drive(input logic rn, input logic av, input logic [VW-1:0] ai,
                         input logic gv, input logic [VW-1:0] gi,
                         input logic ordy, input logic fl);
        @(negedge clk);
        rst_n          = rn;
        bus.act_valid  = av;
        bus.act_in     = ai;
        bus.grad_valid = gv;
        bus.grad_in    = gi;
        bus.out_ready  = ordy;
        bus.flush      = fl;
        #1;
    endtask

    // Advance the model using the driven inputs, then let the clock edge happen.
    task automatic tick();
        logic         push, pop;
        logic [N-1:0] m;
        push = bus.act_valid && (mq.size() < DEPTH) && !bus.flush;
        pop  = bus.grad_valid && (mq.size() > 0) && (!mv || bus.out_ready) && !bus.flush;
        if (!rst_n) begin
            mq.delete();
            mv   = 1'b0;
            mout = '0;
        end else begin
            if (bus.flush) mq.delete();
            if (pop) begin
                m    = mq.pop_front();
                mout = ref_gate(m, bus.grad_in);
                mv   = 1'b1;
            end else if (bus.out_ready) begin
                mv = 1'b0;
            end
            if (push) mq.push_back(ref_mask(bus.act_in));
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b1, '1, 1'b1, 1'b0);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.grad_out !== '0) begin bad++; $display("FAIL reset_grad_out got=%h want=0", bus.grad_out); end
        total++; if (bus.mask_count !== CW'(0)) begin bad++; $display("FAIL reset_mask_count got=%0d want=0", bus.mask_count); end
        total++; if (bus.grad_ready !== 1'b0) begin bad++; $display("FAIL reset_grad_ready got=%b want=0", bus.grad_ready); end
        tick();
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        total++; if (bus.act_ready !== 1'b1) begin bad++; $display("FAIL reset_act_ready got=%b want=1", bus.act_ready); end
        tick();
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b1, pack(0, 1, 123, 32767), 1'b0, '0, 1'b1, 1'b0);
        total++; if (bus.grad_ready !== 1'b0) begin bad++; $display("FAIL basic_empty_grad_ready got=%b want=0", bus.grad_ready); end
        tick();
        drive(1'b1, 1'b0, '0, 1'b1, pack(100, 100, 100, 100), 1'b1, 1'b0);
        total++; if (bus.mask_count !== CW'(1)) begin bad++; $display("FAIL basic_count_before got=%0d want=1", bus.mask_count); end
        total++; if (bus.grad_ready !== 1'b1) begin bad++; $display("FAIL basic_grad_ready got=%b want=1", bus.grad_ready); end
        tick();
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%b want=1", bus.out_valid); end
        total++; if (bus.grad_out !== pack(0, 100, 100, 100)) begin bad++; $display("FAIL basic_grad_out got=%h want=%h", bus.grad_out, pack(0, 100, 100, 100)); end
        total++; if (bus.mask_count !== CW'(0)) begin bad++; $display("FAIL basic_count_after got=%0d want=0", bus.mask_count); end
        tick();
    endtask

    task automatic test_boundaries();
        logic [VW-1:0] exp_v;
`ifdef RELU_BWD_LEAKY_EN
        exp_v = pack(0, -1, 4095, -4096);
`else
        exp_v = pack(0, 0, 0, 0);
`endif
        drive(1'b1, 1'b1, pack(-1, -123, -32768, -5), 1'b0, '0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, '0, 1'b1, pack(7, -7, 32767, -32768), 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bound_out_valid got=%b want=1", bus.out_valid); end
        total++; if (bus.grad_out !== exp_v) begin bad++; $display("FAIL bound_grad_out got=%h want=%h", bus.grad_out, exp_v); end
        tick();
    endtask

    task automatic test_full_empty();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b1, code_vec(i + 5), 1'b0, '0, 1'b1, 1'b0);
            total++; if (bus.act_ready !== 1'b1) begin bad++; $display("FAIL fill_act_ready[%0d] got=%b want=1", i, bus.act_ready); end
            tick();
        end
        drive(1'b1, 1'b1, rand_vec(), 1'b0, '0, 1'b1, 1'b0);
        total++; if (bus.act_ready !== 1'b0) begin bad++; $display("FAIL full_act_ready got=%b want=0", bus.act_ready); end
        total++; if (bus.mask_count !== CW'(DEPTH)) begin bad++; $display("FAIL full_mask_count got=%0d want=%0d", bus.mask_count, DEPTH); end
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, '0, 1'b1, pack(1000 + i, -2000 - i, 3000, -4000), 1'b1, 1'b0);
            total++; if (bus.grad_ready !== 1'b1) begin bad++; $display("FAIL drain_grad_ready[%0d] got=%b want=1", i, bus.grad_ready); end
            if (i > 0) begin
                total++; if (bus.out_valid !== 1'b1 || bus.grad_out !== mout) begin bad++; $display("FAIL drain_order[%0d] got=%b/%h want=1/%h", i, bus.out_valid, bus.grad_out, mout); end
            end
            tick();
        end
        drive(1'b1, 1'b0, '0, 1'b1, rand_vec(), 1'b1, 1'b0);
        total++; if (bus.grad_ready !== 1'b0) begin bad++; $display("FAIL empty_grad_ready got=%b want=0", bus.grad_ready); end
        total++; if (bus.out_valid !== 1'b1 || bus.grad_out !== mout) begin bad++; $display("FAIL drain_last got=%b/%h want=1/%h", bus.out_valid, bus.grad_out, mout); end
        total++; if (bus.mask_count !== CW'(0)) begin bad++; $display("FAIL empty_mask_count got=%0d want=0", bus.mask_count); end
        tick();
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL empty_out_valid got=%b want=0", bus.out_valid); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] held;
        drive(1'b1, 1'b1, code_vec(9), 1'b0, '0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, code_vec(6), 1'b0, '0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, '0, 1'b1, pack(11, 22, 33, 44), 1'b1, 1'b0);
        tick();
        held = mout;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, '0, 1'b1, pack(55, 66, 77, 88), 1'b0, 1'b0);
            total++; if (bus.out_valid !== 1'b1 || bus.grad_out !== held) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h want=1/%h", k, bus.out_valid, bus.grad_out, held); end
            total++; if (bus.grad_ready !== 1'b0) begin bad++; $display("FAIL bp_grad_ready[%0d] got=%b want=0", k, bus.grad_ready); end
            total++; if (bus.mask_count !== CW'(1)) begin bad++; $display("FAIL bp_mask_count[%0d] got=%0d want=1", k, bus.mask_count); end
            tick();
        end
        drive(1'b1, 1'b0, '0, 1'b1, pack(55, 66, 77, 88), 1'b1, 1'b0);
        total++; if (bus.grad_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", bus.grad_ready); end
        tick();
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        total++; if (bus.out_valid !== 1'b1 || bus.grad_out !== mout) begin bad++; $display("FAIL bp_second got=%b/%h want=1/%h", bus.out_valid, bus.grad_out, mout); end
        total++; if (bus.mask_count !== CW'(0)) begin bad++; $display("FAIL bp_count_after got=%0d want=0", bus.mask_count); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, rand_vec(), 1'b0, '0, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b1, rand_vec(), 1'b1, rand_vec(), 1'b1, 1'b0);
            total++; if (bus.mask_count !== CW'(1) || bus.grad_ready !== 1'b1 || bus.act_ready !== 1'b1) begin bad++; $display("FAIL b2b_level[%0d] got=%0d/%b/%b want=1/1/1", k, bus.mask_count, bus.grad_ready, bus.act_ready); end
            if (k > 0) begin
                total++; if (bus.out_valid !== 1'b1 || bus.grad_out !== mout) begin bad++; $display("FAIL b2b_out[%0d] got=%b/%h want=1/%h", k, bus.out_valid, bus.grad_out, mout); end
            end
            tick();
        end
        drive(1'b1, 1'b0, '0, 1'b1, rand_vec(), 1'b1, 1'b0);
        total++; if (bus.out_valid !== 1'b1 || bus.grad_out !== mout) begin bad++; $display("FAIL b2b_last got=%b/%h want=1/%h", bus.out_valid, bus.grad_out, mout); end
        tick();
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        total++; if (bus.out_valid !== 1'b1 || bus.grad_out !== mout) begin bad++; $display("FAIL b2b_tail got=%b/%h want=1/%h", bus.out_valid, bus.grad_out, mout); end
        tick();
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_flush_reset();
        logic [VW-1:0] held;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, code_vec(i + 1), 1'b0, '0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, '0, 1'b1, pack(-300, 400, -500, 600), 1'b0, 1'b0);
        tick();
        held = mout;
        drive(1'b1, 1'b1, rand_vec(), 1'b1, rand_vec(), 1'b0, 1'b1);
        total++; if (bus.mask_count !== CW'(3) || bus.out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre got=%0d/%b want=3/1", bus.mask_count, bus.out_valid); end
        tick();
        drive(1'b1, 1'b0, '0, 1'b1, rand_vec(), 1'b0, 1'b0);
        total++; if (bus.mask_count !== CW'(0)) begin bad++; $display("FAIL flush_mask_count got=%0d want=0", bus.mask_count); end
        total++; if (bus.grad_ready !== 1'b0) begin bad++; $display("FAIL flush_grad_ready got=%b want=0", bus.grad_ready); end
        total++; if (bus.out_valid !== 1'b1 || bus.grad_out !== held) begin bad++; $display("FAIL flush_pending got=%b/%h want=1/%h", bus.out_valid, bus.grad_out, held); end
        tick();
        drive(1'b1, 1'b0, '0, 1'b1, rand_vec(), 1'b1, 1'b0);
        total++; if (bus.grad_ready !== 1'b0) begin bad++; $display("FAIL flush_ready_drain got=%b want=0", bus.grad_ready); end
        tick();
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_drained got=%b want=0", bus.out_valid); end
        tick();
        drive(1'b1, 1'b1, code_vec(15), 1'b0, '0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, code_vec(3), 1'b1, pack(9, 9, 9, 9), 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, rand_vec(), 1'b1, rand_vec(), 1'b0, 1'b0);
        total++; if (bus.out_valid !== 1'b1 || bus.mask_count !== CW'(1)) begin bad++; $display("FAIL rst_pre got=%b/%0d want=1/1", bus.out_valid, bus.mask_count); end
        tick();
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.grad_out !== '0) begin bad++; $display("FAIL midrst_grad_out got=%h want=0", bus.grad_out); end
        total++; if (bus.mask_count !== CW'(0)) begin bad++; $display("FAIL midrst_mask_count got=%0d want=0", bus.mask_count); end
        tick();
    endtask

    task automatic test_random();
        logic av, gv, ordy, fl;
        for (int k = 0; k < 400; k++) begin
            av   = ($urandom_range(0, 1) == 1);
            gv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 31) == 0);
            drive(1'b1, av, rand_vec(), gv, rand_vec(), ordy, fl);
            total++;
            if (bus.mask_count !== CW'(mq.size())
                || bus.act_ready !== (mq.size() != DEPTH)
                || bus.grad_ready !== ((mq.size() != 0) && (!mv || ordy))
                || bus.out_valid !== mv
                || (mv && bus.grad_out !== mout)) begin
                bad++;
                $display("FAIL rand[%0d] got cnt=%0d ar=%b gr=%b ov=%b out=%h want cnt=%0d ar=%b gr=%b ov=%b out=%h",
                         k, bus.mask_count, bus.act_ready, bus.grad_ready, bus.out_valid, bus.grad_out,
                         mq.size(), (mq.size() != DEPTH), ((mq.size() != 0) && (!mv || ordy)), mv, mout);
            end
            tick();
        end
    endtask

    initial begin
        bus.act_valid  = 1'b0;
        bus.act_in     = '0;
        bus.grad_valid = 1'b0;
        bus.grad_in    = '0;
        bus.out_ready  = 1'b0;
        bus.flush      = 1'b0;
        test_reset();
        test_basic();
        test_boundaries();
        test_full_empty();
        test_backpressure();
        test_back_to_back();
        test_flush_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
